load_store_unit: RTL and testbench

- Sits directly upstream of data_memory, between the MIPS MEM pipeline stage and the word-wide, big-endian data memory.
- Converts lb/lbu/lh/lhu/lw/sb/sh/sw requests into whole-word memory accesses.
- Performs read-modify-write for sub-word stores, and extraction plus sign/zero extension for sub-word loads.
- Stalls the pipeline via busy while an access is in flight.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_align.sv | 59 +++++
 rtl/load_store_unit.sv | 198 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings, state type and helpers for load_store_unit.
// LSU_MISALIGN_TRAP_EN adds the ERR state used for misaligned-access traps.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int MEM_LAT_MAX = 7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    DONE = 3'd3
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    ERR  = 3'd4
`endif
  } lsu_state_t;

  // Size 2'b11 is an alias of word.
  function automatic logic is_word(input logic [1:0] size);
    return (size == SZ_WORD) || (size == 2'b11);
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Big-endian sub-word lane logic: extract/extend for loads, merge for stores.
// Halfword lane selection uses off[1] only, so odd halfword offsets force-align.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [4:0]  byte_sh_s;
  logic [4:0]  half_sh_s;
  logic [31:0] byte_mask_s;
  logic [31:0] half_mask_s;

  // Offset 0 is the most significant lane, so masks shift right from the top.
  assign byte_sh_s   = {off, 3'b000};
  assign half_sh_s   = {off[1], 4'b0000};
  assign byte_mask_s = 32'hFF00_0000 >> byte_sh_s;
  assign half_mask_s = 32'hFFFF_0000 >> half_sh_s;

  // Lane select plus extension for loads and lane merge for stores.
  always_comb begin
    load_data  = word;
    store_data = wdata;
    case (off)
      2'd0:    byte_s = word[31:24];
      2'd1:    byte_s = word[23:16];
      2'd2:    byte_s = word[15:8];
      default: byte_s = word[7:0];
    endcase
    if (off[1]) begin
      half_s = word[15:0];
    end else begin
      half_s = word[31:16];
    end
    case (size)
      SZ_BYTE: begin
        load_data  = uns ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
        store_data = (word & ~byte_mask_s) | ({wdata[7:0], 24'h00_0000} >> byte_sh_s);
      end
      SZ_HALF: begin
        load_data  = uns ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
        store_data = (word & ~half_mask_s) | ({wdata[15:0], 16'h0000} >> half_sh_s);
      end
      default: begin
        load_data  = word;
        store_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MIPS load/store unit: turns byte/half/word accesses into word accesses on data_memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses via err instead of force-aligning.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter  int size_ward = 2,
  parameter  int MEM_LAT   = 1,
  localparam int ADDR_W    = $clog2(4 * size_ward)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_memread,
  output logic              mem_memwrite,
  input  logic [31:0]       mem_read_data
);

  localparam int LAT_C = (MEM_LAT < 1) ? 1 : ((MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT);
  localparam logic [2:0] LAT_LAST = 3'(LAT_C - 1);

  lsu_state_t        state_r;
  lsu_state_t        state_nxt_s;
  logic [2:0]        cnt_r;
  logic [2:0]        cnt_nxt_s;
  logic              we_r;
  logic              uns_r;
  logic [1:0]        size_r;
  logic [1:0]        off_r;
  logic [31:0]       wdata_r;
  logic              accept_s;
  logic              rd_last_s;
  logic [31:0]       load_data_s;
  logic [31:0]       store_data_s;
  logic [31:0]       rdata_r;
  logic [31:0]       mem_write_data_r;
  logic [ADDR_W-1:0] mem_address_r;
  logic              busy_r;
  logic              done_r;
  logic              mem_memread_r;
  logic              mem_memwrite_r;

  assign accept_s  = (state_r == IDLE) && req;
  assign rd_last_s = (state_r == RD) && (cnt_r == LAT_LAST);

  lsu_align u_align (
    .word       (mem_read_data),
    .off        (off_r),
    .size       (size_r),
    .uns        (uns_r),
    .wdata      (wdata_r),
    .load_data  (load_data_s),
    .store_data (store_data_s)
  );

  // Next-state and latency counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        cnt_nxt_s = 3'd0;
        if (req) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (is_misaligned(size, addr[1:0])) begin
            state_nxt_s = ERR;
          end else if (we && is_word(size)) begin
            state_nxt_s = WR;
          end else begin
            state_nxt_s = RD;
          end
`else
          if (we && is_word(size)) begin
            state_nxt_s = WR;
          end else begin
            state_nxt_s = RD;
          end
`endif
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD: begin
        if (cnt_r == LAT_LAST) begin
          state_nxt_s = we_r ? WR : DONE;
          cnt_nxt_s   = 3'd0;
        end else begin
          cnt_nxt_s   = cnt_r + 3'd1;
        end
      end
      WR:      state_nxt_s = DONE;
      DONE:    state_nxt_s = IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
      ERR:     state_nxt_s = IDLE;
`endif
      default: state_nxt_s = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Control outputs are registered from the next state so they align with state_r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      mem_memread_r  <= 1'b0;
      mem_memwrite_r <= 1'b0;
    end else begin
      busy_r         <= (state_nxt_s != IDLE);
`ifdef LSU_MISALIGN_TRAP_EN
      done_r         <= (state_nxt_s == DONE) || (state_nxt_s == ERR);
`else
      done_r         <= (state_nxt_s == DONE);
`endif
      mem_memread_r  <= (state_nxt_s == RD);
      mem_memwrite_r <= (state_nxt_s == WR);
    end
  end

  // Request capture, load result and store word registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r             <= 1'b0;
      uns_r            <= 1'b0;
      size_r           <= 2'b00;
      off_r            <= 2'b00;
      wdata_r          <= 32'h0000_0000;
      mem_address_r    <= '0;
      mem_write_data_r <= 32'h0000_0000;
      rdata_r          <= 32'h0000_0000;
    end else begin
      if (accept_s) begin
        we_r          <= we;
        uns_r         <= uns;
        size_r        <= size;
        off_r         <= addr[1:0];
        wdata_r       <= wdata;
        mem_address_r <= {addr[ADDR_W-1:2], 2'b00};
        if (state_nxt_s == WR) begin
          mem_write_data_r <= wdata;
        end
      end
      if (rd_last_s) begin
        if (we_r) begin
          mem_write_data_r <= store_data_s;
        end else begin
          rdata_r <= load_data_s;
        end
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_r;

  // Trap flag, high for the single ERR cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= (state_nxt_s == ERR);
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign rdata          = rdata_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign mem_address    = mem_address_r;
  assign mem_write_data = mem_write_data_r;
  assign mem_memread    = mem_memread_r;
  assign mem_memwrite   = mem_memwrite_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural word memory and reference model.
module tb_load_store_unit;

  localparam int AW      = 3;
  localparam int MEM_LAT = 1;

  logic          clk = 1'b0;
  logic          rst, req, we, uns;
  logic [1:0]    size;
  logic [AW-1:0] addr, mem_address;
  logic [31:0]   wdata, rdata, mem_write_data, mem_read_data;
  logic          busy, done, err, mem_memread, mem_memwrite;

  logic [31:0] dmem [0:1];
  logic [31:0] ref_mem [0:1];
  logic [31:0] ref_rdata;
  logic        pre_en, pre_idx;
  logic [31:0] pre_val;

  int          checks = 0;
  int          failures = 0;
  int          o_lat, o_rd, o_wr, e_lat, e_rd, e_wr;
  logic [31:0] o_wdata, e_wdata;
  logic        o_err, o_addr_ok, o_overlap, e_err;

  load_store_unit #(.size_ward(2), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .uns(uns), .addr(addr),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  assign mem_read_data = dmem[mem_address[2]];

  always @(posedge clk) begin
    if (pre_en) dmem[pre_idx] <= pre_val;
    else if (mem_memwrite) dmem[mem_address[2]] <= mem_write_data;
  end

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz, input logic u, input int off);
    longint v;
    if (sz == 2'b00) begin
      v = longint'((w >> (8 * (3 - off))) & 32'h0000_00FF);
      if (!u && v >= 128) v -= 256;
    end else if (sz == 2'b01) begin
      v = longint'((w >> (16 * (1 - off / 2))) & 32'h0000_FFFF);
      if (!u && v >= 32768) v -= 65536;
    end else begin
      v = longint'(w);
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz, input logic [31:0] d, input int off);
    int sh;
    if (sz == 2'b00) begin
      sh = 8 * (3 - off);
      return (w & ~(32'h0000_00FF << sh)) | ((d & 32'h0000_00FF) << sh);
    end
    sh = 16 * (1 - off / 2);
    return (w & ~(32'h0000_FFFF << sh)) | ((d & 32'h0000_FFFF) << sh);
  endfunction

  // Expected outcome of one access, updating the reference memory and last load result.
  task automatic model_step(input logic w, input logic [1:0] sz, input logic u, input logic [AW-1:0] a, input logic [31:0] d);
    int wi  = int'(a) / 4;
    int off = int'(a) % 4;
    logic [31:0] old = ref_mem[wi];
    e_err = 1'b0; e_wdata = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((sz == 2'b01 && off % 2 == 1) || (sz >= 2'b10 && off != 0)) begin
      e_lat = 1; e_rd = 0; e_wr = 0; e_err = 1'b1;
      return;
    end
`endif
    if (!w) begin
      e_lat = MEM_LAT + 1; e_rd = MEM_LAT; e_wr = 0;
      ref_rdata = ref_load(old, sz, u, off);
    end else if (sz >= 2'b10) begin
      e_lat = 2; e_rd = 0; e_wr = 1; e_wdata = d;
      ref_mem[wi] = d;
    end else begin
      e_lat = MEM_LAT + 2; e_rd = MEM_LAT; e_wr = 1;
      e_wdata = ref_store(old, sz, d, off);
      ref_mem[wi] = e_wdata;
    end
  endtask

  // Issue one request, hold it until done (bounded), and record what the memory side saw.
  task automatic do_access(input logic w, input logic [1:0] sz, input logic u, input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    o_lat = 0; o_rd = 0; o_wr = 0; o_wdata = 32'h0; o_err = 1'b0; o_addr_ok = 1'b1; o_overlap = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_memread) o_rd++;
      if (mem_memwrite) begin o_wr++; o_wdata = mem_write_data; end
      if ((mem_memread || mem_memwrite) && mem_address != {a[AW-1:2], 2'b00}) o_addr_ok = 1'b0;
      if (mem_memread && mem_memwrite) o_overlap = 1'b1;
      if (!busy) o_addr_ok = 1'b0;
      if (done) begin o_lat = k; o_err = err; break; end
      if (k == 1) begin
        we = ~w; size = 2'($urandom_range(0, 3)); addr = 3'($urandom_range(0, 7)); wdata = $urandom();
      end
    end
    req = 1'b0;
  endtask

  task automatic preload(input logic idx, input logic [31:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(negedge clk);
    pre_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = 32'h0;
    pre_en = 1'b0; pre_idx = 1'b0; pre_val = 32'h0; ref_rdata = 32'h0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, err, mem_memread, mem_memwrite} !== 5'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=00000", {busy, done, err, mem_memread, mem_memwrite}); end
    checks++; if ({rdata, mem_write_data, mem_address} !== 67'h0) begin failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", rdata, mem_write_data, mem_address); end
    rst = 1'b0;
    preload(1'b0, 32'h8899_AABB);
    preload(1'b1, 32'h1234_5678);
  endtask

  task automatic test_loads;
    model_step(1'b0, 2'b00, 1'b0, 3'd1, 32'h0);
    do_access(1'b0, 2'b00, 1'b0, 3'd1, 32'h0);
    checks++; if (o_lat !== 2) begin failures++; $display("FAIL lb_latency got=%0d exp=2", o_lat); end
    checks++; if (rdata !== 32'hFFFF_FF99) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffff99", rdata); end
    checks++; if (o_wr !== 0) begin failures++; $display("FAIL lb_no_write got=%0d exp=0", o_wr); end
    model_step(1'b0, 2'b01, 1'b1, 3'd2, 32'h0);
    do_access(1'b0, 2'b01, 1'b1, 3'd2, 32'h0);
    checks++; if (rdata !== 32'h0000_AABB) begin failures++; $display("FAIL lhu_rdata got=%h exp=0000aabb", rdata); end
    model_step(1'b0, 2'b01, 1'b0, 3'd2, 32'h0);
    do_access(1'b0, 2'b01, 1'b0, 3'd2, 32'h0);
    checks++; if (rdata !== 32'hFFFF_AABB) begin failures++; $display("FAIL lh_rdata got=%h exp=ffffaabb", rdata); end
  endtask

  task automatic test_subword_store;
    model_step(1'b1, 2'b00, 1'b0, 3'd3, 32'h0000_0011);
    do_access(1'b1, 2'b00, 1'b0, 3'd3, 32'h0000_0011);
    checks++; if (o_lat !== 3) begin failures++; $display("FAIL sb_latency got=%0d exp=3", o_lat); end
    checks++; if (o_rd !== 1 || o_wr !== 1) begin failures++; $display("FAIL sb_strobes got=rd%0d/wr%0d exp=rd1/wr1", o_rd, o_wr); end
    checks++; if (o_wdata !== 32'h8899_AA11) begin failures++; $display("FAIL sb_merge got=%h exp=8899aa11", o_wdata); end
    checks++; if (rdata !== 32'hFFFF_AABB) begin failures++; $display("FAIL sb_rdata_hold got=%h exp=ffffaabb", rdata); end
    model_step(1'b0, 2'b10, 1'b0, 3'd0, 32'h0);
    do_access(1'b0, 2'b10, 1'b0, 3'd0, 32'h0);
    checks++; if (rdata !== 32'h8899_AA11) begin failures++; $display("FAIL lw_after_sb got=%h exp=8899aa11", rdata); end
  endtask

  task automatic test_word_store;
    model_step(1'b1, 2'b10, 1'b0, 3'd4, 32'hDEAD_BEEF);
    do_access(1'b1, 2'b10, 1'b0, 3'd4, 32'hDEAD_BEEF);
    checks++; if (o_lat !== 2) begin failures++; $display("FAIL sw_latency got=%0d exp=2", o_lat); end
    checks++; if (o_rd !== 0 || o_wr !== 1) begin failures++; $display("FAIL sw_strobes got=rd%0d/wr%0d exp=rd0/wr1", o_rd, o_wr); end
    checks++; if (dmem[1] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw_top_word got=%h exp=deadbeef", dmem[1]); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b01; uns = 1'b0; addr = 3'd0; wdata = 32'h0000_5A5A;
    @(negedge clk);
    checks++; if (mem_memread !== 1'b1) begin failures++; $display("FAIL sh_in_rd got=%b exp=1", mem_memread); end
    rst = 1'b1; req = 1'b0;
    #1;
    checks++; if ({busy, done, err, mem_memread, mem_memwrite} !== 5'b0) begin failures++; $display("FAIL rst_mid_ctrl got=%b exp=00000", {busy, done, err, mem_memread, mem_memwrite}); end
    checks++; if ({rdata, mem_write_data, mem_address} !== 67'h0) begin failures++; $display("FAIL rst_mid_data got=%h/%h/%h exp=0", rdata, mem_write_data, mem_address); end
    @(negedge clk);
    rst = 1'b0;
    ref_rdata = 32'h0;
    repeat (3) @(negedge clk);
    checks++; if (dmem[0] !== ref_mem[0]) begin failures++; $display("FAIL rst_mid_mem got=%h exp=%h", dmem[0], ref_mem[0]); end
    model_step(1'b0, 2'b10, 1'b0, 3'd4, 32'h0);
    do_access(1'b0, 2'b10, 1'b0, 3'd4, 32'h0);
    checks++; if (rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_after_rst got=%h exp=deadbeef", rdata); end
  endtask

  task automatic test_misalign;
    model_step(1'b0, 2'b10, 1'b0, 3'd2, 32'h0);
    do_access(1'b0, 2'b10, 1'b0, 3'd2, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (o_lat !== 1 || o_err !== 1'b1) begin failures++; $display("FAIL mis_trap got=lat%0d/err%b exp=lat1/err1", o_lat, o_err); end
    checks++; if (o_rd + o_wr !== 0) begin failures++; $display("FAIL mis_no_strobe got=%0d exp=0", o_rd + o_wr); end
    checks++; if (rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mis_rdata_hold got=%h exp=deadbeef", rdata); end
`else
    checks++; if (rdata !== 32'h8899_AA11) begin failures++; $display("FAIL mis_align got=%h exp=8899aa11", rdata); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL mis_err got=%b exp=0", o_err); end
`endif
  endtask

  task automatic test_back_to_back(input int n);
    logic w, u;
    logic [1:0] sz;
    logic [AW-1:0] a;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      w = 1'($urandom_range(0, 1)); u = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3)); a = 3'($urandom_range(0, 7)); d = $urandom();
      model_step(w, sz, u, a, d);
      do_access(w, sz, u, a, d);
      checks++; if (o_lat !== e_lat) begin failures++; $display("FAIL rnd_latency i=%0d got=%0d exp=%0d", i, o_lat, e_lat); end
      checks++; if (o_rd !== e_rd || o_wr !== e_wr) begin failures++; $display("FAIL rnd_strobes i=%0d got=rd%0d/wr%0d exp=rd%0d/wr%0d", i, o_rd, o_wr, e_rd, e_wr); end
      checks++; if (e_wr == 1 && o_wdata !== e_wdata) begin failures++; $display("FAIL rnd_wdata i=%0d got=%h exp=%h", i, o_wdata, e_wdata); end
      checks++; if (rdata !== ref_rdata) begin failures++; $display("FAIL rnd_rdata i=%0d got=%h exp=%h", i, rdata, ref_rdata); end
      checks++; if (o_err !== e_err) begin failures++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, o_err, e_err); end
      checks++; if (!o_addr_ok || o_overlap) begin failures++; $display("FAIL rnd_bus i=%0d got=addr_ok%b/overlap%b exp=addr_ok1/overlap0", i, o_addr_ok, o_overlap); end
    end
    checks++; if (dmem[0] !== ref_mem[0] || dmem[1] !== ref_mem[1]) begin failures++; $display("FAIL rnd_mem got=%h_%h exp=%h_%h", dmem[0], dmem[1], ref_mem[0], ref_mem[1]); end
  endtask

  initial begin
    test_reset;
    test_loads;
    test_subword_store;
    test_word_store;
    test_reset_mid;
    test_misalign;
    test_back_to_back(60);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
